vga_overlay_arbiter: RTL

- Shares the single VGA alert-overlay window between the driver-monitor event sources: fatigue alert, 5-hour driving alert, 2-hour driving alert, and the music status banner.
- Queues pulse requests, grants the window by fixed priority, and holds each alert for HOLD_S seconds.
- Supports preemption and user dismissal, and reports the selected overlay code to the VGA pixel mux.
- Sits between the time/fatigue/music processing logic and the VGA display generator.

---
 rtl/vga_overlay_arbiter_if.sv | 30 +++
 rtl/vga_overlay_arbiter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/vga_overlay_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_overlay_arbiter_if
// Description : Request/status bundle between the event sources and the
//               VGA overlay arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_overlay_arbiter_if;
    logic       req_pilao;
    logic       req_drive5;
    logic       req_drive2;
    logic       music_on;
    logic       ack_clear;
    logic [2:0] ovl_sel;
    logic       ovl_active;
    logic [4:0] sec_left;
    logic [2:0] pending;
    logic       done_pulse;

    modport master (
        output req_pilao, req_drive5, req_drive2, music_on, ack_clear,
        input  ovl_sel, ovl_active, sec_left, pending, done_pulse
    );

    modport slave (
        input  req_pilao, req_drive5, req_drive2, music_on, ack_clear,
        output ovl_sel, ovl_active, sec_left, pending, done_pulse
    );
endinterface
`default_nettype wire

// File: rtl/vga_overlay_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vga_overlay_arbiter
// Description : Fixed-priority owner of the VGA alert-overlay window with
//               queued requests, timed hold, preemption and user dismiss.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_overlay_arbiter #(
    parameter int TICK_DIV = 50_000_000,
    parameter int HOLD_S   = 20
) (
    input  wire logic             clk_50M,
    input  wire logic             s_rst_n,
    vga_overlay_arbiter_if.slave  bus
);

    localparam int                 c_CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_TICK_LAST = c_CNT_W'(TICK_DIV - 1);
    localparam logic [4:0]         c_HOLD      = 5'(HOLD_S);

    localparam logic [2:0] c_SEL_NONE   = 3'd0;
    localparam logic [2:0] c_SEL_PILAO  = 3'd1;
    localparam logic [2:0] c_SEL_DRIVE5 = 3'd2;
    localparam logic [2:0] c_SEL_DRIVE2 = 3'd3;
    localparam logic [2:0] c_SEL_MUSIC  = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SHOW = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t             r_state;
    logic [2:0]         r_ovl_sel;
    logic               r_ovl_active;
    logic [4:0]         r_sec_left;
    logic [2:0]         r_pending;
    logic               r_done_pulse;
    logic [c_CNT_W-1:0] r_tick_cnt;

    logic [2:0] w_req;
    logic [2:0] w_shown;
    logic [2:0] w_hi_mask;
    logic [2:0] w_hi_code;
    logic [2:0] w_clr;
    logic [2:0] w_requeue;
    logic [2:0] w_pend_next;
    logic [2:0] w_idle_sel;
    logic       w_grant;
    logic       w_preempt;
    logic       w_retrig;
    logic       w_tick;
    logic       w_end;

    always_comb begin
        w_req   = {bus.req_pilao, bus.req_drive5, bus.req_drive2};
        w_shown = 3'b000;
        if (r_state == S_SHOW) begin
            case (r_ovl_sel)
                c_SEL_PILAO:  w_shown = 3'b100;
                c_SEL_DRIVE5: w_shown = 3'b010;
                c_SEL_DRIVE2: w_shown = 3'b001;
                default:      w_shown = 3'b000;
            endcase
        end

        w_hi_mask = 3'b000;
        w_hi_code = c_SEL_NONE;
        if (r_pending[2]) begin
            w_hi_mask = 3'b100;
            w_hi_code = c_SEL_PILAO;
        end else if (r_pending[1]) begin
            w_hi_mask = 3'b010;
            w_hi_code = c_SEL_DRIVE5;
        end else if (r_pending[0]) begin
            w_hi_mask = 3'b001;
            w_hi_code = c_SEL_DRIVE2;
        end

        w_grant   = (r_state == S_IDLE) && (r_pending != 3'b000);
        // A user dismiss outranks preemption; the dismissed alert is not re-queued.
        w_preempt = (r_state == S_SHOW) && r_pending[2] &&
                    (r_ovl_sel != c_SEL_PILAO) && !bus.ack_clear;
        w_retrig  = |(w_req & w_shown);
        w_tick    = (r_tick_cnt == c_TICK_LAST);
        w_end     = (r_state == S_SHOW) &&
                    (bus.ack_clear ||
                     (!w_preempt && !w_retrig && w_tick && (r_sec_left == 5'd1)));

        w_clr       = (w_grant || w_preempt) ? w_hi_mask : 3'b000;
        w_requeue   = w_preempt ? w_shown : 3'b000;
        // Sets are OR-ed last so a same-edge request beats the grant clear.
        w_pend_next = (r_pending & ~w_clr) | (w_req & ~w_shown) | w_requeue;
        w_idle_sel  = bus.music_on ? c_SEL_MUSIC : c_SEL_NONE;
    end

    always_ff @(posedge clk_50M or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_state      <= S_IDLE;
            r_ovl_sel    <= c_SEL_NONE;
            r_ovl_active <= 1'b0;
            r_sec_left   <= 5'd0;
            r_pending    <= 3'b000;
            r_done_pulse <= 1'b0;
            r_tick_cnt   <= '0;
        end else begin
            r_pending    <= w_pend_next;
            r_done_pulse <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_state      <= S_SHOW;
                        r_ovl_sel    <= w_hi_code;
                        r_ovl_active <= 1'b1;
                        r_sec_left   <= c_HOLD;
                        r_tick_cnt   <= '0;
                    end else begin
                        r_ovl_sel    <= w_idle_sel;
                        r_ovl_active <= 1'b0;
                        r_sec_left   <= 5'd0;
                    end
                end
                S_SHOW: begin
                    if (w_end) begin
                        r_state      <= S_GAP;
                        r_ovl_sel    <= c_SEL_NONE;
                        r_ovl_active <= 1'b0;
                        r_sec_left   <= 5'd0;
                        r_done_pulse <= 1'b1;
                        r_tick_cnt   <= '0;
                    end else if (w_preempt) begin
                        r_ovl_sel    <= c_SEL_PILAO;
                        r_sec_left   <= c_HOLD;
                        r_tick_cnt   <= '0;
                    end else if (w_retrig) begin
                        r_sec_left   <= c_HOLD;
                        r_tick_cnt   <= '0;
                    end else if (w_tick) begin
                        r_sec_left   <= r_sec_left - 5'd1;
                        r_tick_cnt   <= '0;
                    end else begin
                        r_tick_cnt   <= r_tick_cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    r_state      <= S_IDLE;
                    r_ovl_sel    <= w_idle_sel;
                    r_ovl_active <= 1'b0;
                    r_sec_left   <= 5'd0;
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_ovl_sel    <= c_SEL_NONE;
                    r_ovl_active <= 1'b0;
                    r_sec_left   <= 5'd0;
                end
            endcase
        end
    end

    assign bus.ovl_sel    = r_ovl_sel;
    assign bus.ovl_active = r_ovl_active;
    assign bus.sec_left   = r_sec_left;
    assign bus.pending    = r_pending;
    assign bus.done_pulse = r_done_pulse;

endmodule
`default_nettype wire
